// File: rtl/camera_pattern_pkg.sv
// Shared types and constants for the synthetic Bayer camera source.
package camera_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        GRADIENT = 2'd1,
        BARS     = 2'd2,
        CHECKER  = 2'd3
    } pattern_t;

    // Encoded as {row parity, column parity}, BGGR ordering.
    typedef enum logic [1:0] {
        SITE_B  = 2'b00,
        SITE_GB = 2'b01,
        SITE_GR = 2'b10,
        SITE_R  = 2'b11
    } bayer_site_t;

    localparam logic [9:0] FULL_SCALE = 10'h3FF;
    localparam logic [9:0] MID_GREY   = 10'h200;

    function automatic bayer_site_t bayer_site(input logic y_odd, input logic x_odd);
        return bayer_site_t'({y_odd, x_odd});
    endfunction

endpackage

// File: rtl/camera_pattern_generator_if.sv
// Sensor-side pixel stream: run controls in, raw Bayer pixels and framing out.
interface camera_pattern_generator_if;

    logic       enable_in;
    logic [1:0] pattern_select_in;
    logic [9:0] pixel_data_out;
    logic       line_valid_out;
    logic       frame_valid_out;
    logic       frame_done_out;
    logic [7:0] frame_count_out;

    modport master (
        input  enable_in, pattern_select_in,
        output pixel_data_out, line_valid_out, frame_valid_out,
        frame_done_out, frame_count_out
    );

    modport slave (
        output enable_in, pattern_select_in,
        input  pixel_data_out, line_valid_out, frame_valid_out,
        frame_done_out, frame_count_out
    );

endinterface

// File: rtl/camera_pattern_generator_pixel.sv
// Combinational test-pattern value for one Bayer site at (x, y).
module pattern_pixel
    import camera_pattern_pkg::*;
#(
    parameter int IMAGE_X_SIZE = 1288
) (
    input  logic [15:0] i_x,
    input  logic        i_y_odd,
    input  logic        i_y_band,
    input  pattern_t    i_pattern,
    input  logic        i_frame_parity,
    output logic [9:0]  o_pixel
);

    localparam logic [15:0] BAR_WIDTH = 16'(IMAGE_X_SIZE / 8);

    bayer_site_t w_site;
    logic [15:0] w_bar_index;
    logic [2:0]  w_bar;
    logic        w_bar_bit;

    // NOTE: every output of this block is assigned a default first, so no path infers a latch.
    always_comb begin
        w_site      = bayer_site(i_y_odd, i_x[0]);
        w_bar_index = i_x / BAR_WIDTH;
        w_bar       = (w_bar_index > 16'd7) ? 3'd7 : w_bar_index[2:0];
        w_bar_bit   = w_bar[1];
        case (w_site)
            SITE_R:  w_bar_bit = w_bar[2];
            SITE_B:  w_bar_bit = w_bar[0];
            default: w_bar_bit = w_bar[1];
        endcase

        o_pixel = MID_GREY;
        case (i_pattern)
            SOLID:    o_pixel = MID_GREY;
            GRADIENT: o_pixel = (i_x[15:11] != 5'd0) ? FULL_SCALE : i_x[10:1];
            BARS:     o_pixel = w_bar_bit ? FULL_SCALE : 10'h000;
            CHECKER:  o_pixel = (i_x[3] ^ i_y_band ^ i_frame_parity) ? FULL_SCALE : 10'h000;
            default:  o_pixel = MID_GREY;
        endcase
    end

endmodule

// File: rtl/camera_pattern_generator.sv
// Frame/line timing FSM and registered pixel stream of the synthetic camera source.
module camera_pattern_generator
    import camera_pattern_pkg::*;
#(
    parameter int IMAGE_X_SIZE = 1288,
    parameter int IMAGE_Y_SIZE = 768,
    parameter int H_BLANK      = 400,
    parameter int V_BLANK      = 1000,
    parameter int FV_LEAD      = 16
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    camera_pattern_generator_if.master  stream
);

    localparam logic [15:0] X_LAST    = 16'(IMAGE_X_SIZE - 1);
    localparam logic [15:0] Y_LAST    = 16'(IMAGE_Y_SIZE - 1);
    localparam logic [15:0] H_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] V_LAST    = 16'(V_BLANK - 1);
    localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);

    state_t      r_state, w_state_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [15:0] r_y, w_y_next;
    pattern_t    r_pattern;
    logic        w_load_pattern;
    logic        w_frame_end;
    logic [9:0]  w_pixel;

    logic [9:0]  r_pixel;
    logic        r_line_valid;
    logic        r_frame_valid;
    logic        r_frame_done;
    logic [7:0]  r_frame_count;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 16'd1;
        w_y_next       = r_y;
        w_load_pattern = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (stream.enable_in) begin
                    w_state_next   = LEAD;
                    w_load_pattern = 1'b1;
                end
            end
            LEAD: if (r_cnt == LEAD_LAST) begin
                w_state_next = ACTIVE;
                w_cnt_next   = '0;
                w_y_next     = '0;
            end
            ACTIVE: if (r_cnt == X_LAST) begin
                w_state_next = HBLANK;
                w_cnt_next   = '0;
            end
            HBLANK: if (r_cnt == H_LAST) begin
                w_cnt_next = '0;
                if (r_y == Y_LAST) begin
                    w_state_next = VBLANK;
                end else begin
                    w_state_next = ACTIVE;
                    w_y_next     = r_y + 16'd1;
                end
            end
            // enable_in is only honoured here, so a dropped enable lets the frame finish.
            VBLANK: if (r_cnt == V_LAST) begin
                w_cnt_next = '0;
                if (stream.enable_in) begin
                    w_state_next   = LEAD;
                    w_load_pattern = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
        w_frame_end = (r_state == HBLANK) && (w_state_next == VBLANK);
    end

    // Pixel is computed for the coordinate being entered, so it lands with line_valid.
    pattern_pixel #(
        .IMAGE_X_SIZE (IMAGE_X_SIZE)
    ) u_pattern_pixel (
        .i_x            (w_cnt_next),
        .i_y_odd        (w_y_next[0]),
        .i_y_band       (w_y_next[3]),
        .i_pattern      (r_pattern),
        .i_frame_parity (r_frame_count[0]),
        .o_pixel        (w_pixel)
    );

    // NOTE: all state and output flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_y           <= '0;
            r_pattern     <= SOLID;
            r_pixel       <= '0;
            r_line_valid  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_y           <= w_y_next;
            if (w_load_pattern) begin
                r_pattern <= pattern_t'(stream.pattern_select_in);
            end
            r_frame_valid <= (w_state_next == LEAD) || (w_state_next == ACTIVE) ||
                             (w_state_next == HBLANK);
            r_line_valid  <= (w_state_next == ACTIVE);
            r_pixel       <= (w_state_next == ACTIVE) ? w_pixel : 10'h000;
            r_frame_done  <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign stream.pixel_data_out  = r_pixel;
    assign stream.line_valid_out  = r_line_valid;
    assign stream.frame_valid_out = r_frame_valid;
    assign stream.frame_done_out  = r_frame_done;
    assign stream.frame_count_out = r_frame_count;

endmodule

// File: tb/tb_camera_pattern_generator.sv
// Self-checking bench: frame-arithmetic reference model, scenario table, reset and wrap sequences.
module tb_camera_pattern_generator;

    localparam int X    = 16;
    localparam int Y    = 4;
    localparam int H    = 4;
    localparam int V    = 6;
    localparam int LD   = 2;
    localparam int LINE = X + H;
    localparam int FVH  = LD + Y * LINE;
    localparam int PER  = FVH + V;

    logic clk = 1'b0;
    logic rst_n;

    camera_pattern_generator_if cam ();

    camera_pattern_generator #(
        .IMAGE_X_SIZE (X),
        .IMAGE_Y_SIZE (Y),
        .H_BLANK      (H),
        .V_BLANK      (V),
        .FV_LEAD      (LD)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .stream     (cam.master)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] tally;
    logic [9:0] cap [2][X];

    typedef struct {
        int p1;
        int p2;
        int chg_t;
        int nframes;
        int drop_t;
        int exp_fv;
        int exp_bursts;
        int exp_lv;
        int exp_done;
    } scen_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] dut_word();
        return {cam.frame_valid_out, cam.line_valid_out, cam.frame_done_out,
                cam.frame_count_out, cam.pixel_data_out};
    endfunction

    function automatic logic [9:0] ref_pixel(input int x, input int y, input int pat, input int parity);
        int k;
        int b;
        case (pat)
            0: return 10'h200;
            1: return (x / 2 > 1023) ? 10'h3FF : 10'(x / 2);
            2: begin
                k = x / (X / 8);
                if (k > 7) k = 7;
                if (y % 2 == 1 && x % 2 == 1)      b = (k / 4) % 2;
                else if (y % 2 == 0 && x % 2 == 0) b = k % 2;
                else                               b = (k / 2) % 2;
                return (b != 0) ? 10'h3FF : 10'h000;
            end
            default: return ((((x / 8) % 2) ^ ((y / 8) % 2) ^ parity) != 0) ? 10'h3FF : 10'h000;
        endcase
    endfunction

    // Expected outputs at cycle t of a frame period, with cnt completed frames so far.
    function automatic logic [20:0] model_word(input int t, input int pat, input logic [7:0] cnt);
        int u;
        if (t < LD) return {1'b1, 1'b0, 1'b0, cnt, 10'h000};
        if (t < FVH) begin
            u = t - LD;
            if (u % LINE < X)
                return {1'b1, 1'b1, 1'b0, cnt, ref_pixel(u % LINE, u / LINE, pat, int'(cnt[0]))};
            return {1'b1, 1'b0, 1'b0, cnt, 10'h000};
        end
        return {1'b0, 1'b0, (t == FVH), cnt + 8'd1, 10'h000};
    endfunction

    task automatic check_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 32'(dut_word()), 32'({3'b000, tally, 10'h000}));
        end
    endtask

    task automatic run_stream(input int p1, input int p2, input int chg_t, input int nframes,
                              input int drop_t, output int fv_cyc, output int bursts,
                              output int lv_cyc, output int dones);
        logic [7:0] base;
        logic       prev_lv;
        int         f;
        int         pat;
        int         u;
        base    = tally;
        prev_lv = 1'b0;
        fv_cyc  = 0;
        bursts  = 0;
        lv_cyc  = 0;
        dones   = 0;
        @(posedge clk);
        #1;
        cam.pattern_select_in = 2'(p1);
        cam.enable_in         = 1'b1;
        for (int t = 0; t < nframes * PER; t++) begin
            f   = t / PER;
            pat = (chg_t >= 0 && chg_t < f * PER) ? p2 : p1;
            @(posedge clk);
            #1;
            if (t == drop_t) cam.enable_in = 1'b0;
            if (t == chg_t)  cam.pattern_select_in = 2'(p2);
            @(negedge clk);
            check($sformatf("stream t=%0d", t), 32'(dut_word()),
                  32'(model_word(t % PER, pat, base + 8'(f))));
            if (cam.frame_valid_out) fv_cyc++;
            if (cam.line_valid_out) lv_cyc++;
            if (cam.line_valid_out && !prev_lv) bursts++;
            if (cam.frame_done_out) dones++;
            prev_lv = cam.line_valid_out;
            u = t - LD;
            if (p1 == 2 && t < PER && u >= 0 && u < 2 * LINE && u % LINE < X)
                cap[u / LINE][u % LINE] = cam.pixel_data_out;
        end
        tally = base + 8'(nframes);
    endtask

    initial begin
        scen_t      scen [4];
        logic [9:0] bars_exp [2][X];
        int         fv, bu, lv, dn, n, p1, p2;

        scen[0] = '{0, 0, -1, 1, 45,        82,  4,  64, 1};
        scen[1] = '{2, 1, 30, 2, PER + 45,  164, 8, 128, 2};
        scen[2] = '{3, 3, -1, 2, PER + 10,  164, 8, 128, 2};
        scen[3] = '{1, 1, -1, 1, PER - 1,   82,  4,  64, 1};
        bars_exp[0] = '{10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF,
                        10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF};
        bars_exp[1] = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h000,
                        10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};

        tally                 = 8'd0;
        rst_n                 = 1'b0;
        cam.enable_in         = 1'b0;
        cam.pattern_select_in = 2'd0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(dut_word()), 32'h0);
        rst_n = 1'b1;
        check_idle(100, "idle after reset");

        for (int i = 0; i < 4; i++) begin
            run_stream(scen[i].p1, scen[i].p2, scen[i].chg_t, scen[i].nframes, scen[i].drop_t,
                       fv, bu, lv, dn);
            check($sformatf("scen%0d fv cycles", i), 32'(fv), 32'(scen[i].exp_fv));
            check($sformatf("scen%0d lv bursts", i), 32'(bu), 32'(scen[i].exp_bursts));
            check($sformatf("scen%0d lv cycles", i), 32'(lv), 32'(scen[i].exp_lv));
            check($sformatf("scen%0d done pulses", i), 32'(dn), 32'(scen[i].exp_done));
            check_idle(5, $sformatf("scen%0d idle after", i));
        end
        for (int yy = 0; yy < 2; yy++)
            for (int xx = 0; xx < X; xx++)
                check($sformatf("bars y=%0d x=%0d", yy, xx), 32'(cap[yy][xx]), 32'(bars_exp[yy][xx]));

        // Asynchronous reset in the middle of an active line.
        @(posedge clk);
        #1;
        cam.pattern_select_in = 2'd3;
        cam.enable_in         = 1'b1;
        repeat (LD + 6) @(posedge clk);
        @(negedge clk);
        check("line valid before reset", 32'(cam.line_valid_out), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset drops outputs", 32'(dut_word()), 32'h0);
        cam.enable_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tally = 8'd0;
        check_idle(5, "idle after async reset");
        run_stream(3, 3, -1, 1, 40, fv, bu, lv, dn);
        check("clean frame fv cycles", 32'(fv), 32'(FVH));
        check("clean frame lv bursts", 32'(bu), 32'(Y));
        check("clean frame done", 32'(dn), 32'h1);
        check_idle(5, "idle after clean frame");

        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(1, 3));
            p1 = int'($urandom_range(0, 3));
            p2 = int'($urandom_range(0, 3));
            run_stream(p1, p2, int'($urandom_range(0, n * PER - 1)), n,
                       int'($urandom_range((n - 1) * PER, n * PER - 1)), fv, bu, lv, dn);
            check($sformatf("rand%0d fv cycles", r), 32'(fv), 32'(n * FVH));
            check($sformatf("rand%0d done pulses", r), 32'(dn), 32'(n));
            check_idle(3, $sformatf("rand%0d idle after", r));
        end

        // Run past 8'hFF so the frame counter wraps.
        n = 257 - int'(tally);
        run_stream(0, 0, -1, n, n * PER - 1, fv, bu, lv, dn);
        check("wrap done pulses", 32'(dn), 32'(n));
        check_idle(3, "idle after wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
